// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment word rotator: character codes,
// the glyph segment table and the run/stop state encoding.
package seg7_pkg;

  localparam logic [2:0] CH_H     = 3'd0;
  localparam logic [2:0] CH_E     = 3'd1;
  localparam logic [2:0] CH_L     = 3'd2;
  localparam logic [2:0] CH_O     = 3'd3;
  localparam logic [2:0] CH_D     = 3'd4;
  localparam logic [2:0] CH_ONE   = 3'd5;
  localparam logic [2:0] CH_TWO   = 3'd6;
  localparam logic [2:0] CH_BLANK = 3'd7;

  // Entry index is the character code; bit 0 = segment a ... bit 6 = g.
  localparam logic [7:0][6:0] SEG_TABLE = {
    7'b0000000,  // 7 blank
    7'b1011011,  // 6 '2'
    7'b0000110,  // 5 '1'
    7'b1011110,  // 4 'd'
    7'b0111111,  // 3 'O'
    7'b0111000,  // 2 'L'
    7'b1111001,  // 1 'E'
    7'b1110110   // 0 'H'
  };

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_char_decoder.sv
// Combinational character-code to active-high segment pattern lookup.
module seg7_char_decoder
  import seg7_pkg::*;
(
  input  logic [2:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[code_i];
  end

endmodule

// File: rtl/seg7_word_rotator.sv
// N-character word on N 7-segment displays, rotating on a tick or STEP pulse.
// Define SEG7_ACTIVE_LOW_EN for inverted (active-low) HEX outputs.
module seg7_word_rotator
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CHAR_W      = 3,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET,
  input  logic                         LOAD,
  input  logic [NUM_DIGITS*CHAR_W-1:0] WORD,
  input  logic                         RUN,
  input  logic                         STEP,
  input  logic                         DIR,
  output logic [NUM_DIGITS*7-1:0]      HEX,
  output logic [2:0]                   POS,
  output logic                         WRAP
);

  localparam int                WORD_W  = NUM_DIGITS * CHAR_W;
  localparam int                CNT_W   = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_CYCLES - 1);
  localparam logic [2:0]        POS_MAX = 3'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [2:0]              pos_q, pos_d;
  logic                    wrap_q, wrap_d;
  logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
  logic [NUM_DIGITS*7-1:0] seg_all;

  logic running;
  logic tick;
  logic rotate;

  // FSM: state register
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (RUN)  state_d = ST_RUN;
      ST_RUN:  if (!RUN) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  // FSM: outputs
  always_comb begin
    running = (state_q == ST_RUN);
  end

  // Leaving RUN clears the count so a restart always waits a full period.
  always_comb begin
    tick  = running && (cnt_q == CNT_MAX);
    cnt_d = '0;
    if (!LOAD && running && RUN && !tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    rotate = !LOAD && (tick || (!running && STEP));
    word_d = word_q;
    pos_d  = pos_q;
    if (LOAD) begin
      word_d = WORD;
      pos_d  = '0;
    end else if (rotate) begin
      if (!DIR) begin
        word_d = {word_q[WORD_W-CHAR_W-1:0], word_q[WORD_W-1 -: CHAR_W]};
        pos_d  = (pos_q == POS_MAX) ? 3'd0 : pos_q + 3'd1;
      end else begin
        word_d = {word_q[CHAR_W-1:0], word_q[WORD_W-1:CHAR_W]};
        pos_d  = (pos_q == 3'd0) ? POS_MAX : pos_q - 3'd1;
      end
    end
    wrap_d = rotate && (pos_d == 3'd0);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      word_q <= {WORD_W{1'b1}};
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_char_decoder u_dec (
      .code_i (word_q[i*CHAR_W +: CHAR_W]),
      .seg_o  (seg_all[i*7 +: 7])
    );
  end

  always_comb begin
`ifdef SEG7_ACTIVE_LOW_EN
    hex_d = ~seg_all;
`else
    hex_d = seg_all;
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
`ifdef SEG7_ACTIVE_LOW_EN
      hex_q <= {NUM_DIGITS*7{1'b1}};
`else
      hex_q <= '0;
`endif
    end else begin
      hex_q <= hex_d;
    end
  end

  assign HEX  = hex_q;
  assign POS  = pos_q;
  assign WRAP = wrap_q;

endmodule
